// File: rtl/bcd_display_pkg.sv
// rtl/bcd_display_pkg.sv - shared FSM state, seven-segment patterns and double-dabble helper
package bcd_display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Active-low, bit order g..a
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [3:0] dabble_adj(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/seg7_digit_decoder.sv
// rtl/seg7_digit_decoder.sv - BCD nibble to active-low seven-segment pattern
module seg7_digit_decoder
  import bcd_display_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_display_seq.sv
// rtl/bcd_display_seq.sv - iterative double-dabble converter driving DIGITS seven-segment displays
// Optional LEADING_ZERO_BLANK_EN blanks digits above the most significant non-zero digit.
module bcd_display_seq
  import bcd_display_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [7*DIGITS-1:0]   hex_out,
  output logic                  ovf
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int ACC_W = 4 * DIGITS;
  localparam int HEX_W = 7 * DIGITS;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               sticky_q, sticky_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [ACC_W-1:0]   bcd_q, bcd_d;
  logic [HEX_W-1:0]   hex_q, hex_d;
  logic               ovf_q, ovf_d;

  logic [ACC_W-1:0]   acc_adj;
  logic [ACC_W-1:0]   acc_shift;
  logic               ovf_new;
  logic [HEX_W-1:0]   seg_w;
  logic [HEX_W-1:0]   hex_shown;

  always_comb begin
    acc_adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      acc_adj[4*i +: 4] = dabble_adj(acc_q[4*i +: 4]);
    end
  end

  assign acc_shift = {acc_adj[ACC_W-2:0], opnd_q[WIDTH-1]};
  assign ovf_new   = sticky_q | acc_adj[ACC_W-1];

  // Decode the post-shift accumulator so the last SHIFT edge can register the final result.
  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    seg7_digit_decoder u_dec (
      .digit (acc_shift[4*g +: 4]),
      .seg   (seg_w[7*g +: 7])
    );
  end

  always_comb begin
    hex_shown = seg_w;
`ifdef LEADING_ZERO_BLANK_EN
    begin : blank_leading
      logic lead_zero;
      lead_zero = 1'b1;
      for (int i = DIGITS - 1; i > 0; i--) begin
        lead_zero = lead_zero & (acc_shift[4*i +: 4] == 4'd0);
        if (lead_zero && !ovf_new) begin
          hex_shown[7*i +: 7] = SEG_BLANK;
        end
      end
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    sticky_d = sticky_q;
    bcd_d    = bcd_q;
    hex_d    = hex_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SHIFT;
          opnd_d   = in_data;
          acc_d    = '0;
          sticky_d = 1'b0;
          cnt_d    = '0;
        end
      end
      SHIFT: begin
        opnd_d   = opnd_q << 1;
        acc_d    = acc_shift;
        sticky_d = ovf_new;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
          done_d  = 1'b1;
          bcd_d   = acc_shift;
          hex_d   = hex_shown;
          ovf_d   = ovf_new;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      sticky_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      bcd_q    <= '0;
      hex_q    <= {DIGITS{SEG_BLANK}};
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      sticky_q <= sticky_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      bcd_q    <= bcd_d;
      hex_q    <= hex_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd_out = bcd_q;
  assign hex_out = hex_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_bcd_display_seq.sv
// tb/tb_bcd_display_seq.sv - scoreboard bench for bcd_display_seq (3-digit and 2-digit instances)
module tb_bcd_display_seq;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SB = 7'b1111111;

  typedef struct {
    logic [11:0] bcd;
    logic [20:0] hex;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start1, start2;
  logic [7:0]  in1, in2;
  logic        busy1, busy2, done1, done2, ovf1, ovf2;
  logic [11:0] bcd1;
  logic [7:0]  bcd2;
  logic [20:0] hex1;
  logic [13:0] hex2;

  int checks = 0;
  int errors = 0;
  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;

  always #5 clk = ~clk;

  bcd_display_seq #(.WIDTH(8), .DIGITS(3)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .in_data(in1),
    .busy(busy1), .done(done1), .bcd_out(bcd1), .hex_out(hex1), .ovf(ovf1)
  );

  bcd_display_seq #(.WIDTH(8), .DIGITS(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .in_data(in2),
    .busy(busy2), .done(done2), .bcd_out(bcd2), .hex_out(hex2), .ovf(ovf2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && done1 === 1'b1) begin
      if (q1.size() == 0) begin
        chk("unexpected_done1", 32'(done1), 32'd0);
      end else begin
        e1 = q1.pop_front();
        chk("bcd1", 32'(bcd1), 32'(e1.bcd));
        chk("hex1", 32'(hex1), 32'(e1.hex));
        chk("ovf1", 32'(ovf1), 32'(e1.ovf));
      end
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0 && done2 === 1'b1) begin
      if (q2.size() == 0) begin
        chk("unexpected_done2", 32'(done2), 32'd0);
      end else begin
        e2 = q2.pop_front();
        chk("bcd2", 32'(bcd2), 32'(e2.bcd[7:0]));
        chk("hex2", 32'(hex2), 32'(e2.hex[13:0]));
        chk("ovf2", 32'(ovf2), 32'(e2.ovf));
      end
    end
  end

  task automatic wait_idle(input bit sel);
    int n;
    n = 0;
    while (((sel ? busy2 : busy1) !== 1'b0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(sel ? "idle2_timeout" : "idle1_timeout", 32'(n < 40), 32'd1);
  endtask

  task automatic run1(input logic [7:0] v, input logic [11:0] b, input logic [20:0] h,
                      input logic o, input bit timing);
    exp_t e;
    e.bcd = b; e.hex = h; e.ovf = o;
    @(posedge clk); #1;
    start1 = 1'b1; in1 = v;
    q1.push_back(e);
    @(posedge clk); #1;
    start1 = 1'b0;
    if (timing) begin
      for (int k = 1; k <= 10; k++) begin
        @(negedge clk);
        chk($sformatf("busy1_T+%0d", k), 32'(busy1), 32'(k <= 9));
        chk($sformatf("done1_T+%0d", k), 32'(done1), 32'(k == 9));
      end
    end
    wait_idle(1'b0);
  endtask

  task automatic run2(input logic [7:0] v, input logic [7:0] b, input logic [13:0] h, input logic o);
    exp_t e;
    e.bcd = {4'd0, b}; e.hex = {7'd0, h}; e.ovf = o;
    @(posedge clk); #1;
    start2 = 1'b1; in2 = v;
    q2.push_back(e);
    @(posedge clk); #1;
    start2 = 1'b0;
    wait_idle(1'b1);
  endtask

  task automatic chk_reset1(input string tag);
    chk({tag, "_busy"}, 32'(busy1), 32'd0);
    chk({tag, "_done"}, 32'(done1), 32'd0);
    chk({tag, "_bcd"},  32'(bcd1),  32'd0);
    chk({tag, "_ovf"},  32'(ovf1),  32'd0);
    chk({tag, "_hex"},  32'(hex1),  32'h1FFFFF);
    chk({tag, "_hex2"}, 32'(hex2),  32'h3FFF);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start1 = 1'b0; start2 = 1'b0; in1 = 8'd0; in2 = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset1("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    run1(8'd255, 12'h255, {S2, S5, S5}, 1'b0, 1'b1);
`ifdef LEADING_ZERO_BLANK_EN
    run1(8'd0,  12'h000, {SB, SB, S0}, 1'b0, 1'b0);
    run1(8'd42, 12'h042, {SB, S4, S2}, 1'b0, 1'b0);
`else
    run1(8'd0,  12'h000, {S0, S0, S0}, 1'b0, 1'b0);
    run1(8'd42, 12'h042, {S0, S4, S2}, 1'b0, 1'b0);
`endif

    // Second start while busy must be dropped; in_data changes must not matter.
    begin
      exp_t e;
      e.bcd = 12'h100; e.hex = {S1, S0, S0}; e.ovf = 1'b0;
      @(posedge clk); #1;
      start1 = 1'b1; in1 = 8'd100;
      q1.push_back(e);
      @(posedge clk); #1;
      start1 = 1'b0;
      @(posedge clk); #1;
      start1 = 1'b1; in1 = 8'd77;
      @(posedge clk); #1;
      start1 = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      in1 = 8'd55;
      wait_idle(1'b0);
      repeat (14) @(posedge clk);
    end

    run2(8'd200, 8'h00, {S0, S0}, 1'b1);
    run2(8'd99,  8'h99, {S9, S9}, 1'b0);
    run2(8'd100, 8'h00, {S0, S0}, 1'b1);

    // Abort a conversion of 123 during SHIFT cycle 4.
    @(posedge clk); #1;
    start1 = 1'b1; in1 = 8'd123;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_reset1("abort");
    repeat (14) @(posedge clk);

    run1(8'd123, 12'h123, {S1, S2, S3}, 1'b0, 1'b1);

    repeat (4) @(posedge clk);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    chk("q2_drained", 32'(q2.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
